// File: rtl/multi_fan_pwm.sv
// Multi-channel fan PWM generator: one shared period counter, per-channel
// kick-start / rate-limited ramp state machines, registered PWM outputs.
module multi_fan_pwm #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 1,
    parameter int RAMP_STEP    = 1,
    parameter int RAMP_PERIODS = 1,
    parameter int KICK_PERIODS = 2
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] speed,
    output logic [CHANNELS-1:0]       pwm_data,
    output logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       ramping,
    output logic                      period_start
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RC_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam int KC_W  = (KICK_PERIODS > 0) ? $clog2(KICK_PERIODS + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RAMP_PERIODS - 1);
    localparam logic [KC_W-1:0]  KC_LOAD  = KC_W'(KICK_PERIODS);
    localparam logic [KC_W-1:0]  KC_ONE   = KC_W'(1);
    localparam logic [WIDTH-1:0] STEP_N   = WIDTH'(RAMP_STEP);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, KICK, RUN} state_t;

    logic [PRE_W-1:0] pre_q;
    logic [WIDTH-1:0] cnt_q;
    logic [RC_W-1:0]  rc_q;
    logic             tick;
    logic             boundary;
    logic             ramp_ev;

    // One ramp step toward tgt, clamped at tgt; the extra bit catches carry/borrow.
    function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                      input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] up;
        logic [WIDTH:0] dn;
        up = {1'b0, cur} + STEP_W;
        dn = {1'b0, cur} - STEP_W;
        if (cur < tgt)
            ramp_toward = (up > {1'b0, tgt}) ? tgt : up[WIDTH-1:0];
        else
            ramp_toward = (dn[WIDTH] || (dn[WIDTH-1:0] < tgt)) ? tgt : dn[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] start_duty(input logic [WIDTH-1:0] tgt);
        start_duty = (tgt < STEP_N) ? tgt : STEP_N;
    endfunction

    assign tick     = (pre_q == PRE_LAST);
    assign boundary = tick && (cnt_q == CNT_LAST);
    assign ramp_ev  = boundary && (rc_q == RC_LAST);

    always_ff @(posedge clk) begin
        if (arst) begin
            pre_q        <= '0;
            cnt_q        <= '0;
            rc_q         <= '0;
            period_start <= 1'b0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick)
                cnt_q <= boundary ? '0 : cnt_q + 1'b1;
            if (boundary)
                rc_q <= ramp_ev ? '0 : rc_q + 1'b1;
            period_start <= boundary;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [KC_W-1:0]  kc_q, kc_d;
        logic [WIDTH-1:0] duty_q, duty_d;
        logic [WIDTH-1:0] tgt;
        logic             pwm_q, pwm_d;
        logic             ramp_q, ramp_d;

        assign tgt = en[i] ? speed[i*WIDTH +: WIDTH] : '0;

        always_ff @(posedge clk) begin
            if (arst) begin
                state_q <= IDLE;
                kc_q    <= '0;
                duty_q  <= '0;
                pwm_q   <= 1'b0;
                ramp_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                kc_q    <= kc_d;
                duty_q  <= duty_d;
                pwm_q   <= pwm_d;
                if (boundary)
                    ramp_q <= ramp_d;
            end
        end

        // State and duty only move on a period boundary, so no period is cut short.
        always_comb begin
            state_d = state_q;
            kc_d    = kc_q;
            duty_d  = duty_q;
            if (boundary) begin
                case (state_q)
                    IDLE: begin
                        if (tgt != '0) begin
                            if (KICK_PERIODS > 0) begin
                                state_d = KICK;
                                kc_d    = KC_LOAD;
                            end else begin
                                state_d = RUN;
                                duty_d  = start_duty(tgt);
                            end
                        end
                    end
                    KICK: begin
                        if (tgt == '0) begin
                            state_d = IDLE;
                            kc_d    = '0;
                            duty_d  = '0;
                        end else if (kc_q <= KC_ONE) begin
                            state_d = RUN;
                            kc_d    = '0;
                            duty_d  = tgt;
                        end else begin
                            kc_d = kc_q - KC_ONE;
                        end
                    end
                    RUN: begin
                        if (ramp_ev) begin
                            duty_d = ramp_toward(duty_q, tgt);
                            if (duty_d == '0)
                                state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        kc_d    = '0;
                        duty_d  = '0;
                    end
                endcase
            end
        end

        always_comb begin
            pwm_d  = (state_q == KICK) || (cnt_q < duty_q);
            ramp_d = (state_d == KICK) || (duty_d != tgt);
        end

        assign pwm_data[i]                = pwm_q;
        assign ramping[i]                 = ramp_q;
        assign duty[i*WIDTH +: WIDTH]     = duty_q;
    end

endmodule

// File: tb/tb_multi_fan_pwm.sv
// Bench for multi_fan_pwm: two instances (default and prescaled/no-kick) checked
// cycle by cycle against a period-level behavioural model plus literal scenario values.
module tb_multi_fan_pwm;

    logic        clk;
    logic        arst;
    logic [3:0]  en_a;
    logic [31:0] speed_a;
    logic [3:0]  pwm_a;
    logic [31:0] duty_a;
    logic [3:0]  ramp_a;
    logic        ps_a;
    logic [2:0]  en_b;
    logic [23:0] speed_b;
    logic [2:0]  pwm_b;
    logic [23:0] duty_b;
    logic [2:0]  ramp_b;
    logic        ps_b;

    int vectors;
    int miscompares;

    multi_fan_pwm #(.CHANNELS(4)) dut_a (
        .clk(clk), .arst(arst), .en(en_a), .speed(speed_a),
        .pwm_data(pwm_a), .duty(duty_a), .ramping(ramp_a), .period_start(ps_a)
    );

    multi_fan_pwm #(.CHANNELS(3), .WIDTH(8), .PRESCALE(4), .RAMP_STEP(4),
                    .RAMP_PERIODS(1), .KICK_PERIODS(0)) dut_b (
        .clk(clk), .arst(arst), .en(en_b), .speed(speed_b),
        .pwm_data(pwm_b), .duty(duty_b), .ramping(ramp_b), .period_start(ps_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model configuration per instance: prescale, step, ramp periods, kick periods, channels.
    localparam int PRE[2]  = '{1, 4};
    localparam int STP[2]  = '{1, 4};
    localparam int RPD[2]  = '{1, 1};
    localparam int KPD[2]  = '{2, 0};
    localparam int NCH[2]  = '{4, 3};

    int md_e;
    int md_mode[2][4];
    int md_kl[2][4];
    int md_duty[2][4];
    bit md_pwm[2][4];
    bit md_ramp[2][4];
    bit md_ps[2];

    task automatic model_reset();
        md_e = 0;
        for (int k = 0; k < 2; k++) begin
            md_ps[k] = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                md_mode[k][ch] = 0;
                md_kl[k][ch]   = 0;
                md_duty[k][ch] = 0;
                md_pwm[k][ch]  = 1'b0;
                md_ramp[k][ch] = 1'b0;
            end
        end
    endtask

    // Period-level view: edge md_e ends a period when it is a multiple of 255*PRESCALE.
    task automatic model_edge(input int k, input logic [3:0] e_in, input logic [31:0] s_in);
        int per;
        int cb;
        int t;
        bit bnd;
        bit rev;
        per = 255 * PRE[k];
        cb  = ((md_e - 1) / PRE[k]) % 255;
        bnd = (md_e % per) == 0;
        rev = bnd && (((md_e / per) % RPD[k]) == 0);
        md_ps[k] = bnd;
        for (int ch = 0; ch < NCH[k]; ch++) begin
            md_pwm[k][ch] = (md_mode[k][ch] == 1) || (cb < md_duty[k][ch]);
            if (bnd) begin
                t = e_in[ch] ? int'(s_in[ch*8 +: 8]) : 0;
                if (md_mode[k][ch] == 0) begin
                    if (t != 0) begin
                        if (KPD[k] > 0) begin
                            md_mode[k][ch] = 1;
                            md_kl[k][ch]   = KPD[k];
                        end else begin
                            md_mode[k][ch] = 2;
                            md_duty[k][ch] = (STP[k] < t) ? STP[k] : t;
                        end
                    end
                end else if (md_mode[k][ch] == 1) begin
                    if (t == 0) begin
                        md_mode[k][ch] = 0;
                        md_duty[k][ch] = 0;
                    end else begin
                        md_kl[k][ch] = md_kl[k][ch] - 1;
                        if (md_kl[k][ch] == 0) begin
                            md_mode[k][ch] = 2;
                            md_duty[k][ch] = t;
                        end
                    end
                end else if (rev) begin
                    if (md_duty[k][ch] < t)
                        md_duty[k][ch] = (md_duty[k][ch] + STP[k] > t) ? t : md_duty[k][ch] + STP[k];
                    else
                        md_duty[k][ch] = (md_duty[k][ch] - STP[k] < t) ? t : md_duty[k][ch] - STP[k];
                    if (md_duty[k][ch] == 0)
                        md_mode[k][ch] = 0;
                end
                md_ramp[k][ch] = (md_mode[k][ch] == 1) || (md_duty[k][ch] != t);
            end
        end
    endtask

    function automatic logic [40:0] exp_a();
        logic [3:0]  p;
        logic [3:0]  r;
        logic [31:0] d;
        for (int ch = 0; ch < 4; ch++) begin
            p[ch] = md_pwm[0][ch];
            r[ch] = md_ramp[0][ch];
            d[ch*8 +: 8] = 8'(md_duty[0][ch]);
        end
        return {p, d, r, md_ps[0]};
    endfunction

    function automatic logic [30:0] exp_b();
        logic [2:0]  p;
        logic [2:0]  r;
        logic [23:0] d;
        for (int ch = 0; ch < 3; ch++) begin
            p[ch] = md_pwm[1][ch];
            r[ch] = md_ramp[1][ch];
            d[ch*8 +: 8] = 8'(md_duty[1][ch]);
        end
        return {p, d, r, md_ps[1]};
    endfunction

    // Advance one clock: update the model from the inputs present at the edge.
    task automatic step();
        @(posedge clk);
        if (arst) begin
            model_reset();
        end else begin
            md_e++;
            model_edge(0, en_a, speed_a);
            model_edge(1, {1'b0, en_b}, {8'h00, speed_b});
        end
        #1;
    endtask

    task automatic test_reset();
        int n;
        arst    = 1'b1;
        en_a    = 4'hF;
        speed_a = {4{8'd200}};
        en_b    = 3'b111;
        speed_b = {3{8'd200}};
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if ({pwm_a, duty_a, ramp_a, ps_a} !== 41'h0) begin
            miscompares++;
            $display("FAIL reset_a: got=%h want=0", {pwm_a, duty_a, ramp_a, ps_a});
        end
        vectors++;
        if ({pwm_b, duty_b, ramp_b, ps_b} !== 31'h0) begin
            miscompares++;
            $display("FAIL reset_b: got=%h want=0", {pwm_b, duty_b, ramp_b, ps_b});
        end
        arst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            vectors++;
            if ({pwm_a, duty_a, ramp_a, ps_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL reset_run e=%0d got=%h want=%h", md_e, {pwm_a, duty_a, ramp_a, ps_a}, exp_a());
            end
        end while (!ps_a && n < 300);
        vectors++;
        if (n != 255) begin
            miscompares++;
            $display("FAIL first_period_start: cycles=%0d want=255", n);
        end
        vectors++;
        if (ramp_a !== 4'hF) begin
            miscompares++;
            $display("FAIL kick_ramping: got=%b want=1111", ramp_a);
        end
        step();
        vectors++;
        if (pwm_a !== 4'hF) begin
            miscompares++;
            $display("FAIL kick_pwm_after_release: got=%b want=1111", pwm_a);
        end
        en_b = 3'b000;
    endtask

    task automatic test_kick();
        int n;
        int hi;
        arst = 1'b1;
        step();
        step();
        vectors++;
        if ({pwm_a, ramp_a, duty_a} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_mid_kick: got=%h want=0", {pwm_a, ramp_a, duty_a});
        end
        arst    = 1'b0;
        en_a    = 4'b0001;
        speed_a = 32'h0000_0002;
        n = 0;
        do begin
            step();
            n++;
        end while (!ps_a && n < 300);
        vectors++;
        if (!ps_a || ramp_a[0] !== 1'b1 || duty_a[7:0] !== 8'd0) begin
            miscompares++;
            $display("FAIL kick_entry: ps=%b ramp=%b duty=%0d want ps=1 ramp=1 duty=0", ps_a, ramp_a[0], duty_a[7:0]);
        end
        hi = 0;
        for (int i = 0; i < 510; i++) begin
            step();
            hi += int'(pwm_a[0]);
            vectors++;
            if ({pwm_a, duty_a, ramp_a, ps_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL kick_cycle e=%0d got=%h want=%h", md_e, {pwm_a, duty_a, ramp_a, ps_a}, exp_a());
            end
        end
        vectors++;
        if (hi != 510) begin
            miscompares++;
            $display("FAIL kick_high_cycles: got=%0d want=510", hi);
        end
        vectors++;
        if (duty_a[7:0] !== 8'd2 || ramp_a[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL kick_to_run: duty=%0d ramp=%b want duty=2 ramp=0", duty_a[7:0], ramp_a[0]);
        end
        hi = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            hi += int'(pwm_a[0]);
        end
        vectors++;
        if (hi != 2) begin
            miscompares++;
            $display("FAIL run_duty2_high: got=%0d want=2", hi);
        end
    endtask

    task automatic test_abort_kick();
        int n;
        arst = 1'b1;
        step();
        arst    = 1'b0;
        en_a    = 4'b0010;
        speed_a = 32'h0000_9600;
        n = 0;
        do begin
            step();
            n++;
        end while (!ps_a && n < 300);
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (pwm_a[1] !== 1'b1 || ramp_a[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_mid_kick: pwm=%b ramp=%b want 1 1", pwm_a[1], ramp_a[1]);
        end
        en_a = 4'b0000;
        n = 0;
        do begin
            step();
            n++;
            vectors++;
            if ({pwm_a, duty_a, ramp_a, ps_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL abort_cycle e=%0d got=%h want=%h", md_e, {pwm_a, duty_a, ramp_a, ps_a}, exp_a());
            end
        end while (!ps_a && n < 300);
        vectors++;
        if (!ps_a || duty_a[15:8] !== 8'd0 || ramp_a[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_boundary: ps=%b duty=%0d ramp=%b want 1 0 0", ps_a, duty_a[15:8], ramp_a[1]);
        end
        step();
        vectors++;
        if (pwm_a[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pwm: got=%b want=0", pwm_a[1]);
        end
    endtask

    task automatic test_extremes();
        int n;
        int bad;
        arst = 1'b1;
        step();
        arst    = 1'b0;
        en_a    = 4'b0101;
        speed_a = {8'd255, 8'd0, 8'd77, 8'd255};
        for (int b = 0; b < 3; b++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!ps_a && n < 300);
        end
        vectors++;
        if (duty_a !== {8'd0, 8'd0, 8'd0, 8'd255} || ramp_a !== 4'b0000) begin
            miscompares++;
            $display("FAIL extremes_duty: duty=%h ramp=%b want duty=000000ff ramp=0", duty_a, ramp_a);
        end
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (pwm_a !== 4'b0001) bad++;
            vectors++;
            if ({pwm_a, duty_a, ramp_a, ps_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL extremes_cycle e=%0d got=%h want=%h", md_e, {pwm_a, duty_a, ramp_a, ps_a}, exp_a());
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL extremes_glitch: bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_random();
        arst = 1'b1;
        step();
        arst    = 1'b0;
        en_a    = 4'($urandom);
        speed_a = $urandom;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                en_a    = 4'($urandom);
                speed_a = $urandom;
                if ($urandom_range(0, 3) == 0) speed_a[7:0] = 8'd255;
            end
            step();
            vectors++;
            if ({pwm_a, duty_a, ramp_a, ps_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL random e=%0d got=%h want=%h", md_e, {pwm_a, duty_a, ramp_a, ps_a}, exp_a());
            end
        end
    endtask

    task automatic test_prescale();
        int n;
        int hi0;
        int hi2;
        arst = 1'b1;
        step();
        arst    = 1'b0;
        en_a    = 4'b0000;
        en_b    = 3'b101;
        speed_b = {8'd20, 8'd99, 8'd64};
        for (int b = 0; b < 16; b++) begin
            n = 0;
            do begin
                step();
                n++;
                vectors++;
                if ({pwm_b, duty_b, ramp_b, ps_b} !== exp_b()) begin
                    miscompares++;
                    $display("FAIL prescale_cycle e=%0d got=%h want=%h", md_e, {pwm_b, duty_b, ramp_b, ps_b}, exp_b());
                end
            end while (!ps_b && n < 1100);
        end
        vectors++;
        if (duty_b !== {8'd20, 8'd0, 8'd64}) begin
            miscompares++;
            $display("FAIL prescale_duty: got=%h want=140040", duty_b);
        end
        n = 0;
        hi0 = 0;
        hi2 = 0;
        do begin
            step();
            n++;
            hi0 += int'(pwm_b[0]);
            hi2 += int'(pwm_b[2]);
        end while (!ps_b && n < 1100);
        vectors++;
        if (n != 1020 || hi0 != 256 || hi2 != 80) begin
            miscompares++;
            $display("FAIL prescale_period: len=%0d hi0=%0d hi2=%0d want 1020 256 80", n, hi0, hi2);
        end
    endtask

    task automatic test_ramp_down();
        int n;
        int want[3] = '{60, 56, 54};
        speed_b[7:0] = 8'd54;
        for (int i = 0; i < 100; i++) step();
        vectors++;
        if (duty_b[7:0] !== 8'd64) begin
            miscompares++;
            $display("FAIL midperiod_hold: got=%0d want=64", duty_b[7:0]);
        end
        for (int j = 0; j < 3; j++) begin
            n = 0;
            do begin
                step();
                n++;
                vectors++;
                if ({pwm_b, duty_b, ramp_b, ps_b} !== exp_b()) begin
                    miscompares++;
                    $display("FAIL ramp_cycle e=%0d got=%h want=%h", md_e, {pwm_b, duty_b, ramp_b, ps_b}, exp_b());
                end
            end while (!ps_b && n < 1100);
            vectors++;
            if (duty_b[7:0] !== 8'(want[j]) || ramp_b[0] !== (j < 2) ||
                ramp_b[2] !== 1'b0 || duty_b[23:16] !== 8'd20) begin
                miscompares++;
                $display("FAIL ramp_down_%0d: duty0=%0d ramp=%b duty2=%0d want duty0=%0d", j,
                         duty_b[7:0], ramp_b, duty_b[23:16], want[j]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        arst        = 1'b1;
        en_a        = '0;
        speed_a     = '0;
        en_b        = '0;
        speed_b     = '0;
        model_reset();
        test_reset();
        test_kick();
        test_abort_kick();
        test_extremes();
        test_random();
        test_prescale();
        test_ramp_down();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_fan_pwm.md
# multi_fan_pwm

Parametrised multi-channel fan PWM generator for the smart-home climate path, successor to the single-channel 8-bit fan speed block. Generates CHANNELS PWM outputs from one shared period counter. Each channel has an enable, glitch-free duty updates at period boundaries, rate-limited ramping toward the requested speed, and a full-duty kick-start when a stopped fan is commanded on. Sits between the climate controller (speed requests) and the fan driver pins.

## Interface
- CHANNELS, 4: number of independent fan channels (≥1).
- WIDTH, 8: speed/duty width; MAX = 2^WIDTH − 1; PWM period = MAX ticks.
- PRESCALE, 1: clk cycles per PWM tick (≥1).
- RAMP_STEP, 1: duty change per ramp event (1..MAX).
- RAMP_PERIODS, 1: PWM periods between ramp events (≥1).
- KICK_PERIODS, 2: full-duty periods on start-from-zero (0 disables kick).

- clk  in  1  system clock; all logic on rising edge.
- arst  in  1  reset; synchronous, active-high.
- en  in  CHANNELS  per-channel enable; effective target is 0 when low.
- speed  in  CHANNELS*WIDTH  packed requested duty, channel i at [i*WIDTH +: WIDTH]; sampled only at period boundaries.
- pwm_data  out  CHANNELS  registered PWM outputs.
- duty  out  CHANNELS*WIDTH  current applied duty per channel (packed like speed).
- ramping  out  CHANNELS  high while applied duty ≠ effective target or kick is active.
- period_start  out  1  one-cycle pulse in the first clk cycle with cnt = 0 after a boundary.

## Operation
- Prescaler pre_q counts 0..PRESCALE−1; tick = (pre_q == PRESCALE−1). PRESCALE=1 → tick every cycle.
- Period counter cnt_q counts 0..MAX−1, advancing on tick. Boundary = tick && cnt_q == MAX−1; cnt_q wraps to 0.
- Shared ramp counter rc_q counts boundaries 0..RAMP_PERIODS−1. A ramp event is a boundary with rc_q == RAMP_PERIODS−1.
- Per channel, target T = en[i] ? speed[i] : 0, evaluated at a boundary. States:
  - IDLE (duty 0): on a boundary with T ≠ 0 → KICK if KICK_PERIODS > 0 (kick count loaded KICK_PERIODS); otherwise RUN with duty = min(RAMP_STEP, T).
  - KICK: output forced high. Each boundary decrements the count. If T = 0 at a boundary → IDLE, duty 0, immediately. When the count reaches 0 → RUN with duty = T.
  - RUN: on a ramp event, duty moves toward T by RAMP_STEP, saturating exactly at T (no overshoot, no wrap). Reaching duty 0 → IDLE.
- Duty changes only at boundaries, so a period is never truncated.
- pwm_data[i] next = kick[i] || (cnt_q < duty[i]). Duty 0 → constantly low. Duty MAX → constantly high.
- Arithmetic: ramp uses WIDTH+1-bit intermediate; up: min(duty+STEP, T); down: max(duty−STEP, T).

## Timing
- Reset values, applied on the first clk edge with arst high: pre_q, cnt_q, rc_q = 0; all channels IDLE; duty = 0; pwm_data = 0; ramping = 0; period_start = 0. Reset mid-period or mid-kick aborts everything on that edge. After release, counting resumes from cnt 0.
- Boundary edge: cnt_q becomes 0, and duty/state update on the same edge. pwm_data reflects the new duty one clk later (registered output; 1-cycle latency from cnt_q).
- period_start is high in the cycle after the boundary edge, for one cycle.
- Simultaneous events: a kick start and a ramp event on the same boundary → kick wins. Changing en or speed between boundaries has no effect until the next boundary.
- Period length = MAX × PRESCALE clk cycles. The high-time per period = duty × PRESCALE cycles.

## Test plan
- Reset: hold arst for 3 cycles with en = all 1s and speed = 200 on all channels → pwm_data = 0, duty = 0, period_start = 0. First period_start pulses 255 cycles after release; kick follows (defaults).
- Kick: en[0] = 1, speed[0] = 2 (defaults) → pwm_data[0] is high continuously for 510 cycles. Then duty = 2: high 2 cycles of every 255.
- Ramp down: in RUN at duty 100, with RAMP_STEP = 4, RAMP_PERIODS = 1, set speed = 90 → duty reads 96, 92, 90 at successive boundaries; ramping drops with the third. A mid-period speed change does not alter the current period.
- Abort kick: drop en[1] during its first kick period → at the next boundary pwm_data[1] = 0, duty = 0, ramping = 0.
- Extremes: duty 255 → pwm_data high every cycle. Duty 0 → never high. Neither shows a one-cycle glitch at the wrap.
- Prescale: PRESCALE = 4, duty 64 (KICK_PERIODS = 0, RAMP_STEP = 255) → period 1020 cycles, high 256 cycles. Channels are independent: a different duty on channel 2 does not perturb channel 0.
